// File: rtl/shift_add_mult_cntlr_if.sv
// rtl/shift_add_mult_cntlr_if.sv - start/ready handshake and operand/product bus for the shift-add multiplier
interface shift_add_mult_cntlr_if #(
  parameter int dp_width = 8
);
  logic                    start;
  logic [dp_width-1:0]     multiplicand;
  logic [dp_width-1:0]     multiplier;
  logic                    ready;
  logic                    done;
  logic [2*dp_width-1:0]   product;

  modport master (
    output start, multiplicand, multiplier,
    input  ready, done, product
  );

  modport slave (
    input  start, multiplicand, multiplier,
    output ready, done, product
  );
endinterface

// File: rtl/shift_add_mult_cntlr.sv
// rtl/shift_add_mult_cntlr.sv - sequential unsigned shift-and-add multiplier with three-state controller
module shift_add_mult_cntlr #(
  parameter int dp_width  = 8,
  parameter int cnt_width = $clog2(dp_width + 1)
) (
  input  logic                  clk,
  input  logic                  rst_b,
  shift_add_mult_cntlr_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_ADD   = 2'b01,
    S_SHIFT = 2'b10
  } state_t;

  localparam logic [cnt_width-1:0] P_INIT = cnt_width'(dp_width);

  state_t                state_q, state_d;
  logic                  done_q, done_d;
  logic [dp_width-1:0]   a_q, b_q, q_q;
  logic                  c_q;
  logic [cnt_width-1:0]  p_q;

  // control strobes to the datapath and status back from it
  logic load_regs, add_regs, shift_regs, decr_p;
  logic q0, zero;

  assign q0   = q_q[0];
  assign zero = (p_q == '0);

  // next-state and strobe decode; unused encoding falls back to idle
  always_comb begin
    state_d    = S_IDLE;
    done_d     = 1'b0;
    load_regs  = 1'b0;
    add_regs   = 1'b0;
    shift_regs = 1'b0;
    decr_p     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          load_regs = 1'b1;
          state_d   = S_ADD;
        end else begin
          state_d   = S_IDLE;
        end
      end
      S_ADD: begin
        decr_p   = 1'b1;
        add_regs = q0;
        state_d  = S_SHIFT;
      end
      S_SHIFT: begin
        shift_regs = 1'b1;
        if (zero) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          state_d = S_ADD;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // controller state and registered done pulse
  always_ff @(posedge clk) begin
    if (!rst_b) begin
      state_q <= S_IDLE;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
    end
  end

  // datapath: A/B/Q/C registers and iteration counter P
  always_ff @(posedge clk) begin
    if (!rst_b) begin
      a_q <= '0;
      b_q <= '0;
      q_q <= '0;
      c_q <= 1'b0;
      p_q <= '0;
    end else begin
      if (load_regs) begin
        a_q <= '0;
        c_q <= 1'b0;
        b_q <= bus.multiplicand;
        q_q <= bus.multiplier;
        p_q <= P_INIT;
      end
      if (decr_p) begin
        p_q <= p_q - cnt_width'(1);
      end
      if (add_regs) begin
        {c_q, a_q} <= {1'b0, a_q} + {1'b0, b_q};
      end
      // logical right shift of {C,A,Q}; C always empties
      if (shift_regs) begin
        c_q <= 1'b0;
        a_q <= {c_q, a_q[dp_width-1:1]};
        q_q <= {a_q[0], q_q[dp_width-1:1]};
      end
    end
  end

  assign bus.ready   = (state_q == S_IDLE);
  assign bus.done    = done_q;
  assign bus.product = {a_q, q_q};

endmodule

// File: tb/tb_shift_add_mult_cntlr.sv
// tb/tb_shift_add_mult_cntlr.sv - self-checking bench for the shift-add multiplier
module tb_shift_add_mult_cntlr;

  localparam int W = 8;

  logic clk;
  logic rst_b;
  int   checks;
  int   failures;

  shift_add_mult_cntlr_if #(.dp_width(W)) bus ();

  shift_add_mult_cntlr #(.dp_width(W)) dut (
    .clk   (clk),
    .rst_b (rst_b),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits for ready after an accepted start; checks latency, done pulse and product.
  task automatic wait_done(input logic [2*W-1:0] exp, input bit noisy);
    int n;
    n = 0;
    while (bus.ready !== 1'b1 && n < 40) begin
      check("done_low_busy", {31'b0, bus.done}, 32'h0);
      if (noisy) begin
        bus.start        = 1'($urandom);
        bus.multiplicand = 8'($urandom);
        bus.multiplier   = 8'($urandom);
      end
      tick();
      n++;
    end
    if (noisy) bus.start = 1'b0;
    check("latency", n, 2 * W);
    check("done_pulse", {31'b0, bus.done}, 32'h1);
    check("product", {16'b0, bus.product}, {16'b0, exp});
  endtask

  task automatic start_op(input logic [W-1:0] mc, input logic [W-1:0] mp, input bit noisy);
    logic [2*W-1:0] exp;
    exp = (2*W)'(mc) * (2*W)'(mp);
    bus.start        = 1'b1;
    bus.multiplicand = mc;
    bus.multiplier   = mp;
    tick();
    bus.start = 1'b0;
    check("ready_drop", {31'b0, bus.ready}, 32'h0);
    wait_done(exp, noisy);
    tick();
    check("done_one_cycle", {31'b0, bus.done}, 32'h0);
    check("ready_hold", {31'b0, bus.ready}, 32'h1);
    check("product_hold", {16'b0, bus.product}, {16'b0, exp});
  endtask

  initial begin
    checks           = 0;
    failures         = 0;
    rst_b            = 1'b0;
    bus.start        = 1'b0;
    bus.multiplicand = '0;
    bus.multiplier   = '0;
    tick();
    tick();
    rst_b = 1'b1;

    // idle after reset
    for (int i = 0; i < 5; i++) begin
      tick();
      check("rst_ready", {31'b0, bus.ready}, 32'h1);
      check("rst_done", {31'b0, bus.done}, 32'h0);
      check("rst_product", {16'b0, bus.product}, 32'h0);
    end

    // directed operands
    start_op(8'h0F, 8'h0F, 1'b0);
    start_op(8'hFF, 8'hFF, 1'b0);
    start_op(8'h00, 8'hA5, 1'b0);
    start_op(8'h80, 8'h02, 1'b0);

    // start held high: back-to-back with a single done/idle cycle between
    bus.start        = 1'b1;
    bus.multiplicand = 8'h03;
    bus.multiplier   = 8'h05;
    tick();
    bus.multiplicand = 8'h07;
    bus.multiplier   = 8'h09;
    wait_done(16'h000F, 1'b0);
    tick();
    check("b2b_ready", {31'b0, bus.ready}, 32'h0);
    check("b2b_done", {31'b0, bus.done}, 32'h0);
    wait_done(16'h003F, 1'b0);
    bus.start = 1'b0;
    tick();
    check("b2b_end_ready", {31'b0, bus.ready}, 32'h1);

    // inputs disturbed mid-operation
    start_op(8'h12, 8'h34, 1'b1);

    // reset in the middle of an operation
    bus.start        = 1'b1;
    bus.multiplicand = 8'hC3;
    bus.multiplier   = 8'h5A;
    tick();
    bus.start = 1'b0;
    repeat (5) tick();
    rst_b = 1'b0;
    tick();
    rst_b = 1'b1;
    check("midrst_ready", {31'b0, bus.ready}, 32'h1);
    check("midrst_done", {31'b0, bus.done}, 32'h0);
    check("midrst_product", {16'b0, bus.product}, 32'h0);
    start_op(8'h12, 8'h34, 1'b0);

    // randomized operands against plain multiplication
    for (int i = 0; i < 8; i++) begin
      start_op(8'($urandom), 8'($urandom), 1'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/shift_add_mult_cntlr.md
Name: shift_add_mult_cntlr

Overview:
Sequential shift-and-add binary multiplier for unsigned operands. It contains a three-state controller (S_idle, S_add, S_shift) and the datapath that controller sequences: registers A, B, Q, carry flip-flop C, and a down-counter P. The block sits beside the ones-counter controller in the chapter-8 register-transfer designs. It is the next controller/datapath pair, driven by a start/ready handshake.

Parameters:
dp_width, 8, operand width W in bits; legal range 2..32
cnt_width, $clog2(dp_width+1), width of counter P; derived, not overridden

Ports:
clk  input  1  clock; all state updates on rising edge
rst_b  input  1  reset; synchronous, active-low
start  input  1  request to begin a multiplication; sampled only in S_idle
multiplicand  input  dp_width  operand loaded into B when start is accepted
multiplier  input  dp_width  operand loaded into Q when start is accepted
ready  output  1  high while in S_idle
done  output  1  registered one-cycle pulse when a multiplication completes
product  output  2*dp_width  {A,Q}; valid while ready=1, until the next accepted start

Behaviour:
- Reset (rst_b=0 at a rising edge), regardless of state, including mid-operation:
  - state=S_idle
  - A=0, B=0, Q=0, C=0, P=0
  - done=0
  - so ready=1 and product=0 after the edge
- State encoding: 2-bit; S_idle=2'b00, S_add=2'b01, S_shift=2'b10. Unused code 2'b11 goes to S_idle on the next edge.
- S_idle:
  - ready=1.
  - If start=1: A<=0, C<=0, B<=multiplicand, Q<=multiplier, P<=dp_width; go to S_add.
  - Otherwise hold all registers.
- S_add:
  - P<=P-1.
  - If Q[0]=1: {C,A}<=A+B, a (dp_width+1)-bit sum so the carry is captured in C.
  - If Q[0]=0: A and C hold.
  - Always go to S_shift.
- S_shift:
  - {C,A,Q}<={C,A,Q}>>1, with C<=0 (logical right shift of the combined register).
  - If P==0 (the value already decremented in S_add): go to S_idle and set done<=1.
  - Otherwise go to S_add.
- done: high for exactly the one cycle after the final S_shift edge; 0 in every other cycle.
- start while not in S_idle: ignored, with no effect on registers or the sequence.
- Latency:
  - start accepted at edge t0.
  - The block spends exactly 2*dp_width cycles alternating S_add/S_shift.
  - ready and done rise together at edge t0+2*dp_width.
  - product is valid from that edge.
- Back-to-back operation: if start=1 in the done cycle, a new operation is accepted at the next edge. product is then overwritten: A=0, Q=new multiplier.
- product width is exactly 2*dp_width. The maximum result (2^W-1)^2 fits with no overflow. C is always 0 after each shift.
- Operand inputs are sampled only at the accepting edge. Changes during S_add/S_shift have no effect.
- Implementation split: the controller is a next-state block plus a registered state. The datapath is a separate sequential block driven by internal control strobes (load_regs, add_regs, shift_regs, decr_p) and returns status (q0, zero).

Test Plan:
- Reset release, start=0 for 5 cycles -> ready=1, done=0, product=16'h0000; state stays S_idle.
- dp_width=8: multiplicand=8'h0F, multiplier=8'h0F, start pulsed 1 cycle -> ready low for 16 cycles; done high exactly 1 cycle at edge 16; product=16'h00E1.
- multiplicand=8'hFF, multiplier=8'hFF (carry path in C exercised) -> product=16'hFE01 after 16 cycles. Also 8'h00 x 8'hA5 -> 16'h0000. Also 8'h80 x 8'h02 -> 16'h0100.
- start held high continuously with operands 8'h03 x 8'h05, then 8'h07 x 8'h09 -> done pulses every 17 cycles; products 16'h000F then 16'h003F; no idle gap beyond the single done cycle.
- start toggled and operands changed during S_add/S_shift -> sequence length and result unaffected. Example: 8'h12 x 8'h34 gives 16'h03A8.
- rst_b driven low for 1 cycle at cycle 6 of a multiplication -> next edge: ready=1, done=0, product=0. A new start after that gives a correct result with full 16-cycle latency.
